mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl_pkg.sv | 24 ++
 rtl/mem_bus_ctrl_if.sv | 14 +
 rtl/mem_bus_ctrl.sv | 70 +++++++
 tb/tb_mem_bus_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl_pkg: shared defines, FSM encoding and SRAM widths for the MEM-stage SRAM controller
package mem_bus_ctrl_pkg;
  localparam logic RstEnable = 1'b1;
  localparam logic Stop = 1'b1;
  localparam int DataW = 32;
  localparam logic [DataW-1:0] ZeroWord = '0;
  localparam int RamAddrW = 20;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD1 = 3'd1;
  localparam logic [2:0] ST_RD2 = 3'd2;
  localparam logic [2:0] ST_WR_SETUP = 3'd3;
  localparam logic [2:0] ST_WR_PULSE = 3'd4;
  localparam logic [2:0] ST_WR_HOLD = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;
  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    RD1 = ST_RD1,
    RD2 = ST_RD2,
    WR_SETUP = ST_WR_SETUP,
    WR_PULSE = ST_WR_PULSE,
    WR_HOLD = ST_WR_HOLD,
    DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: pipeline MEM-stage access bus between the pipeline (master) and the SRAM controller (slave)
interface mem_bus_ctrl_if;
  import mem_bus_ctrl_pkg::*;
  logic req_i;
  logic we_i;
  logic [DataW-1:0] addr_i;
  logic [3:0] sel_i;
  logic [DataW-1:0] wdata_i;
  logic flush_i;
  logic [DataW-1:0] rdata_o;
  logic stallreq_o;
  modport master (output req_i, we_i, addr_i, sel_i, wdata_i, flush_i, input rdata_o, stallreq_o);
  modport slave (input req_i, we_i, addr_i, sel_i, wdata_i, flush_i, output rdata_o, stallreq_o);
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: multi-cycle asynchronous SRAM sequencer for MEM-stage loads and stores, stalling the pipeline while busy
module mem_bus_ctrl import mem_bus_ctrl_pkg::*; (
  input logic clk,
  input logic rst,
  mem_bus_ctrl_if.slave bus,
  output logic [RamAddrW-1:0] ram_addr_o,
  output logic [DataW-1:0] ram_wdata_o,
  output logic ram_data_oe_o,
  input logic [DataW-1:0] ram_rdata_i,
  output logic ram_ce_n_o,
  output logic ram_oe_n_o,
  output logic ram_we_n_o,
  output logic [3:0] ram_be_n_o
);
  state_t state, nxt;
  logic [RamAddrW-1:0] addr_q;
  logic [3:0] sel_q;
  logic [DataW-1:0] data_q;
  logic abort_q;
  logic in_rst, start, busy, rd, wr;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[31:22], bus.addr_i[1:0]};
  assign in_rst = rst == RstEnable;
  assign start = state == IDLE && bus.req_i && !bus.flush_i;
  assign busy = state inside {RD1, RD2, WR_SETUP, WR_PULSE, WR_HOLD};
  assign rd = state inside {RD1, RD2};
  assign wr = state inside {WR_SETUP, WR_PULSE, WR_HOLD};
  always_ff @(posedge clk) begin
    if (in_rst) begin
      state <= IDLE;
      addr_q <= '0;
      sel_q <= '0;
      data_q <= ZeroWord;
      abort_q <= 1'b0;
      bus.rdata_o <= ZeroWord;
    end else begin
      state <= nxt;
      abort_q <= state == WR_PULSE && bus.flush_i;
      if (start) begin
        addr_q <= bus.addr_i[21:2];
        sel_q <= bus.sel_i;
        data_q <= bus.wdata_i;
      end
      if (state == RD2 && !bus.flush_i) bus.rdata_o <= ram_rdata_i;
    end
  end
  // a flush caught in WR_PULSE still finishes the pulse and hold, then bypasses DONE
  always_comb begin
    nxt = IDLE;
    unique case (state)
      IDLE: nxt = start ? (bus.we_i ? WR_SETUP : RD1) : IDLE;
      RD1: nxt = bus.flush_i ? IDLE : RD2;
      RD2: nxt = bus.flush_i ? IDLE : DONE;
      WR_SETUP: nxt = bus.flush_i ? IDLE : WR_PULSE;
      WR_PULSE: nxt = WR_HOLD;
      WR_HOLD: nxt = (bus.flush_i || abort_q) ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.stallreq_o = (!in_rst && !bus.flush_i && (busy || (state == IDLE && bus.req_i))) ? Stop : ~Stop;
    ram_ce_n_o = in_rst || !busy;
    ram_oe_n_o = in_rst || !rd;
    ram_we_n_o = in_rst || state != WR_PULSE;
    ram_data_oe_o = !in_rst && wr;
    ram_be_n_o = (in_rst || state == IDLE) ? 4'hF : ~sel_q;
    ram_addr_o = addr_q;
    ram_wdata_o = data_q;
  end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: randomized scoreboard bench with an SRAM model plus directed flush and reset scenarios
module tb_mem_bus_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mem_bus_ctrl_if bus();
  logic [19:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic ram_data_oe, ce_n, oe_n, we_n;
  logic [3:0] be_n;
  mem_bus_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_data_oe_o(ram_data_oe),
    .ram_rdata_i(ram_rdata), .ram_ce_n_o(ce_n), .ram_oe_n_o(oe_n),
    .ram_we_n_o(we_n), .ram_be_n_o(be_n)
  );
  typedef struct {
    logic we;
    logic [19:0] idx;
    logic [3:0] ben;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t got;
  int errors = 0, checks = 0;
  int stall_cnt = 0, wen_cnt = 0, doe_cnt = 0, we_total = 0;
  logic mon_en, mem_init;
  logic [31:0] last_rd;
  logic [31:0] sram [256];
  logic [31:0] ref_mem [256];
  function automatic logic [31:0] init_word(int i);
    return i == 4 ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  assign ram_rdata = (!ce_n && !oe_n) ? sram[ram_addr[7:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
    else if (!ce_n && !we_n && ram_data_oe)
      for (int b = 0; b < 4; b++) if (!be_n[b]) sram[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
  end
  always @(negedge clk) begin
    if (!we_n) we_total++;
    check("oe_vs_data_oe", {31'b0, !(!oe_n && ram_data_oe)}, 32'd1);
    if (mon_en && bus.req_i && !bus.flush_i) begin
      if (!we_n) wen_cnt++;
      if (ram_data_oe) doe_cnt++;
      if (!ce_n && sb.size() > 0) begin
        check("ram_addr", {12'b0, ram_addr}, {12'b0, sb[0].idx});
        check("be_n", {28'b0, be_n}, {28'b0, sb[0].ben});
      end
      if (bus.stallreq_o) stall_cnt++;
      else if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: completion seen with no expected access");
      end else begin
        got = sb.pop_front();
        check("stall_cycles", stall_cnt, got.we ? 4 : 3);
        check("we_n_pulses", wen_cnt, got.we ? 1 : 0);
        check("data_oe_cycles", doe_cnt, got.we ? 3 : 0);
        check("rdata", bus.rdata_o, got.rdata);
        stall_cnt = 0;
        wen_cnt = 0;
        doe_cnt = 0;
      end
    end
  end
  task automatic access(input logic we, input logic [7:0] idx, input logic [3:0] sel, input logic [31:0] wd, input int gap);
    exp_t e;
    int n;
    logic [9:0] hi;
    logic [1:0] lo;
    hi = 10'($urandom);
    lo = 2'($urandom);
    @(posedge clk); #1;
    bus.req_i = 1'b1;
    bus.we_i = we;
    bus.addr_i = {hi, 12'b0, idx, lo};
    bus.sel_i = sel;
    bus.wdata_i = wd;
    e.we = we;
    e.idx = {12'b0, idx};
    e.ben = ~sel;
    if (we) begin
      for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
    end else last_rd = ref_mem[idx];
    e.rdata = last_rd;
    sb.push_back(e);
    n = 0;
    @(negedge clk);
    while (bus.stallreq_o && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (bus.stallreq_o) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: stallreq still 1 after %0d cycles", n);
    end
    if (gap > 0) begin
      @(posedge clk); #1;
      bus.req_i = 1'b0;
      repeat (gap - 1) @(posedge clk);
    end
  endtask
  task automatic start_req(input logic we, input logic [7:0] idx, input logic [31:0] wd);
    @(posedge clk); #1;
    bus.req_i = 1'b1;
    bus.we_i = we;
    bus.addr_i = {22'b0, idx, 2'b0};
    bus.sel_i = 4'hF;
    bus.wdata_i = wd;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int w0;
    rst = 1'b1;
    mem_init = 1'b1;
    mon_en = 1'b0;
    last_rd = 32'h0;
    bus.req_i = 1'b0;
    bus.we_i = 1'b0;
    bus.addr_i = 32'h0;
    bus.sel_i = 4'h0;
    bus.wdata_i = 32'h0;
    bus.flush_i = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    check("rst_stall", {31'b0, bus.stallreq_o}, 32'd0);
    check("rst_ce_oe_we", {29'b0, ce_n, oe_n, we_n}, 32'd7);
    check("rst_be_n", {28'b0, be_n}, 32'hF);
    check("rst_data_oe", {31'b0, ram_data_oe}, 32'd0);
    check("rst_rdata", bus.rdata_o, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1'b1;
    access(1'b0, 8'd4, 4'hF, 32'h0, 0);
    access(1'b1, 8'd8, 4'b0011, 32'h12345678, 0);
    access(1'b0, 8'd8, 4'hF, 32'h0, 1);
    check("store_low_half", {16'b0, ref_mem[8][15:0]}, 32'h5678);
    repeat (150) access(1'($urandom), 8'($urandom), 4'($urandom), $urandom, $urandom_range(0, 2));
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    mon_en = 1'b0;
    check("sb_drained", sb.size(), 32'd0);
    w0 = we_total;
    start_req(1'b1, 8'd9, 32'hCAFEF00D);
    @(posedge clk); #1 bus.flush_i = 1'b1;
    @(negedge clk);
    check("fl_setup_stall", {31'b0, bus.stallreq_o}, 32'd0);
    check("fl_setup_ce_n", {31'b0, ce_n}, 32'd0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    bus.req_i = 1'b0;
    @(negedge clk);
    check("fl_setup_idle", {27'b0, ce_n, be_n}, 32'h1F);
    check("fl_setup_no_we", we_total, w0);
    start_req(1'b1, 8'd10, 32'h0BADC0DE);
    ref_mem[10] = 32'h0BADC0DE;
    @(posedge clk);
    @(posedge clk); #1 bus.flush_i = 1'b1;
    @(negedge clk);
    check("fl_pulse_we_n", {31'b0, we_n}, 32'd0);
    check("fl_pulse_stall", {31'b0, bus.stallreq_o}, 32'd0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    bus.req_i = 1'b0;
    @(negedge clk);
    check("fl_hold", {29'b0, ce_n, we_n, ram_data_oe}, 32'd3);
    @(posedge clk);
    @(negedge clk);
    check("fl_hold_skip_done", {27'b0, ce_n, be_n}, 32'h1F);
    check("fl_hold_data_oe", {31'b0, ram_data_oe}, 32'd0);
    @(posedge clk); #1;
    bus.req_i = 1'b1;
    bus.we_i = 1'b0;
    bus.addr_i = 32'h10;
    bus.flush_i = 1'b1;
    @(negedge clk);
    check("fl_idle_stall", {31'b0, bus.stallreq_o}, 32'd0);
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("fl_idle_stays", {31'b0, ce_n}, 32'd1);
    start_req(1'b0, 8'd12, 32'h0);
    @(posedge clk);
    @(posedge clk); #1 bus.flush_i = 1'b1;
    @(negedge clk);
    check("fl_rd2_oe_n", {31'b0, oe_n}, 32'd0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    bus.req_i = 1'b0;
    @(negedge clk);
    check("fl_rd2_rdata", bus.rdata_o, last_rd);
    check("fl_rd2_idle", {31'b0, ce_n}, 32'd1);
    start_req(1'b1, 8'd11, 32'h55AA55AA);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_pulse_outs", {28'b0, we_n, bus.stallreq_o, ram_data_oe, ce_n}, 32'h9);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_i = 1'b0;
    @(negedge clk);
    check("rst_after_we_ce", {30'b0, we_n, ce_n}, 32'd3);
    check("rst_after_rdata", bus.rdata_o, 32'h0);
    check("rst_after_addr", {12'b0, ram_addr}, 32'h0);
    last_rd = 32'h0;
    mon_en = 1'b1;
    access(1'b0, 8'd10, 4'hF, 32'h0, 1);
    access(1'b0, 8'd11, 4'hF, 32'h0, 1);
    access(1'b0, 8'd9, 4'hF, 32'h0, 1);
    mon_en = 1'b0;
    check("sb_final", sb.size(), 32'd0);
    for (int i = 0; i < 256; i++) check("sram_word", sram[i], ref_mem[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
